// File: rtl/uart_receiver_pkg.sv
// ---------------------------------------------------------------------------
// uart_receiver_pkg
// Shared types and constants for the UART receive front end.
//   UartRxState_t   : receiver FSM state encoding
//   UART_OVERSAMPLE : ticks per bit period
//   calc_div        : rounded clocks-per-oversample-tick from clock and baud
// ---------------------------------------------------------------------------
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } UartRxState_t;

    localparam int UART_OVERSAMPLE = 16;

    // Rounded division: round(clk_freq / (baud * 16)), never below 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + (baud * UART_OVERSAMPLE) / 2) / (baud * UART_OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator. Counts 0..DIV-1 and flags the last count.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : forces the counter back to 0 (aligns ticks to a start edge)
//   tick    : high while the counter sits at DIV-1
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    // A one-bit counter is kept even for DIV=1 so the width is never zero.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || (cnt_reg == LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 16x oversampling 8N1 receiver feeding the VT100 parser (no backpressure).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   data       : last good byte (changes only together with dataReady)
//   dataReady  : one-cycle strobe, data valid in that cycle
//   frameError : one-cycle strobe when the stop bit sampled low
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       frameError
);

    // ---------------- synchroniser ----------------
    logic sync1_reg;
    logic rxs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rxs_reg   <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            rxs_reg   <= sync1_reg;
        end
    end

    // ---------------- tick generator ----------------
    logic tick;
    logic restart;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // ---------------- state and datapath registers ----------------
    UartRxState_t state_reg;
    UartRxState_t state_next;

    logic [3:0] sc_reg;        // tick within bit, wraps every 16 ticks
    logic [2:0] bc_reg;        // data bit index
    logic [2:0] samp_reg;      // samples taken at ticks 7, 8, 9
    logic       bit_valid_reg; // a data bit has been voted in this bit period
    logic [7:0] shift_reg;
    logic [7:0] data_reg;
    logic       ready_reg;
    logic       ferr_reg;

    // ---------------- majority voter ----------------
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // At tick 9 the third sample is still on rxs, so vote on it directly.
    logic vote_now;
    logic vote_held;
    logic at_tick9;
    logic at_tick15;

    assign vote_now  = maj3(samp_reg[0], samp_reg[1], rxs_reg);
    assign vote_held = maj3(samp_reg[0], samp_reg[1], samp_reg[2]);
    assign at_tick9  = tick && (sc_reg == 4'd9);
    assign at_tick15 = tick && (sc_reg == 4'd15);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    logic shift_en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!rxs_reg) state_next = START;
            START: if (at_tick9) state_next = vote_now ? IDLE : DATA;
            DATA:  if (shift_en && (bc_reg == 3'd7)) state_next = STOP;
            STOP:  if (at_tick9) state_next = vote_now ? IDLE : BREAK;
            BREAK: if (rxs_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic ready_next;
    logic ferr_next;

    always_comb begin
        restart    = 1'b0;
        shift_en   = 1'b0;
        ready_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            IDLE:  restart  = !rxs_reg;
            // The first tick 15 after entering DATA still belongs to the
            // start bit; bit_valid_reg keeps it from being shifted in.
            DATA:  shift_en = at_tick15 && bit_valid_reg;
            STOP: begin
                ready_next = at_tick9 && vote_now;
                ferr_next  = at_tick9 && !vote_now;
            end
            default: ;
        endcase
    end

    // ---------------- counters, samples and shift register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_reg        <= '0;
            bc_reg        <= '0;
            samp_reg      <= '0;
            bit_valid_reg <= 1'b0;
            shift_reg     <= '0;
        end else begin
            if (restart) begin
                sc_reg <= '0;
            end else if (tick && (state_reg != IDLE) && (state_reg != BREAK)) begin
                sc_reg <= sc_reg + 1'b1;
            end

            if (tick) begin
                case (sc_reg)
                    4'd7:    samp_reg[0] <= rxs_reg;
                    4'd8:    samp_reg[1] <= rxs_reg;
                    4'd9:    samp_reg[2] <= rxs_reg;
                    default: ;
                endcase
            end

            if ((state_reg == START) && at_tick9) begin
                bc_reg        <= '0;
                bit_valid_reg <= 1'b0;
            end else if ((state_reg == DATA) && at_tick9) begin
                bit_valid_reg <= 1'b1;
            end else if (shift_en) begin
                bit_valid_reg <= 1'b0;
            end

            if (shift_en) begin
                shift_reg[bc_reg] <= vote_held;
                bc_reg            <= bc_reg + 1'b1;
            end
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            ready_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            ferr_reg  <= ferr_next;
            if (ready_next) begin
                data_reg <= shift_reg;
            end
        end
    end

    assign data       = data_reg;
    assign dataReady  = ready_reg;
    assign frameError = ferr_reg;

endmodule
